// File: rtl/tgmux_pkg.sv
// Shared types and constants for the transmission-gate mux select controller.
package tgmux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAKE  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_BREAK = 2'd3
    } tgmux_state_t;

    localparam int CNT_W          = 4;
    localparam int DEF_DEAD_CYC   = 2;
    localparam int DEF_SETTLE_CYC = 3;

    // Width of the saturating hold-time counter for a given limit.
    function automatic int to_cnt_width(input int hold_max);
        return $clog2(hold_max + 1);
    endfunction

endpackage

// File: rtl/tgmux_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or above ptr, with wrap.
module tgmux_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan from the farthest offset down so the nearest one at/after ptr wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin : scan
            int j;
            j = int'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (req[j]) begin
                idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/tgmux_sel_ctrl.sv
// Break-before-make select controller for a shared transmission-gate mux node.
// Optional hold timeout is compiled in with `define TGMUX_TIMEOUT_EN.
module tgmux_sel_ctrl
    import tgmux_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DEAD_CYC   = DEF_DEAD_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int HOLD_MAX   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         ckn,
    output logic [N_REQ-1:0]         ckp,
    output logic [$clog2(N_REQ)-1:0] sel,
    output logic                     busy,
    output logic                     to_pulse
);

    localparam int IDX_W = $clog2(N_REQ);

    tgmux_state_t     state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [IDX_W-1:0] sel_reg, sel_next;
    logic [N_REQ-1:0] gnt_reg, gnt_next;
    logic [N_REQ-1:0] ckn_reg, ckn_next;
    logic [N_REQ-1:0] ckp_reg, ckp_next;
    logic             busy_reg, busy_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] pick_onehot;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             req_sel;
    logic [IDX_W-1:0] ptr_after_sel;

`ifdef TGMUX_TIMEOUT_EN
    localparam int TO_W = to_cnt_width(HOLD_MAX);

    logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
    logic             to_pulse_reg, to_pulse_next;
    logic [N_REQ-1:0] blocked_reg, blocked_next;

    // A timed-out requester stays masked until it is seen low at an edge.
    assign eligible = req & ~blocked_reg;
    assign to_pulse = to_pulse_reg;
`else
    assign eligible = req;
    assign to_pulse = 1'b0;
`endif

    tgmux_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (eligible),
        .ptr   (ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pick_dec
            assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
        end
    endgenerate

    assign req_sel       = req[sel_reg];
    assign ptr_after_sel = (sel_reg == IDX_W'(N_REQ - 1)) ? '0 : sel_reg + IDX_W'(1);

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        sel_next   = sel_reg;
        gnt_next   = gnt_reg;
        ckn_next   = ckn_reg;
        cnt_next   = cnt_reg;
`ifdef TGMUX_TIMEOUT_EN
        to_cnt_next   = to_cnt_reg;
        to_pulse_next = 1'b0;
        blocked_next  = blocked_reg & req;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = ST_MAKE;
                    ckn_next   = pick_onehot;
                    sel_next   = pick_idx;
                    cnt_next   = '0;
                end
            end

            ST_MAKE: begin
                if (!req_sel) begin
                    state_next = ST_BREAK;
                    ckn_next   = '0;
                    gnt_next   = '0;
                    cnt_next   = '0;
                    ptr_next   = ptr_after_sel;
                end else if (cnt_reg == CNT_W'(SETTLE_CYC - 1)) begin
                    state_next = ST_HOLD;
                    gnt_next   = ckn_reg;
                    cnt_next   = '0;
`ifdef TGMUX_TIMEOUT_EN
                    to_cnt_next = '0;
`endif
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_HOLD: begin
                if (!req_sel) begin
                    state_next = ST_BREAK;
                    ckn_next   = '0;
                    gnt_next   = '0;
                    cnt_next   = '0;
                    ptr_next   = ptr_after_sel;
`ifdef TGMUX_TIMEOUT_EN
                end else if (to_cnt_reg == TO_W'(HOLD_MAX - 1)) begin
                    state_next             = ST_BREAK;
                    ckn_next               = '0;
                    gnt_next               = '0;
                    cnt_next               = '0;
                    ptr_next               = ptr_after_sel;
                    to_pulse_next          = 1'b1;
                    blocked_next[sel_reg]  = 1'b1;
                end else if (to_cnt_reg != '1) begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
`endif
                end
            end

            ST_BREAK: begin
                if (cnt_reg == CNT_W'(DEAD_CYC - 1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
                ckn_next   = '0;
                gnt_next   = '0;
                cnt_next   = '0;
            end
        endcase

        // Gate pair drives are registered together so they never disagree.
        ckp_next  = ~ckn_next;
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            sel_reg   <= '0;
            gnt_reg   <= '0;
            ckn_reg   <= '0;
            ckp_reg   <= '1;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
`ifdef TGMUX_TIMEOUT_EN
            to_cnt_reg   <= '0;
            to_pulse_reg <= 1'b0;
            blocked_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            sel_reg   <= sel_next;
            gnt_reg   <= gnt_next;
            ckn_reg   <= ckn_next;
            ckp_reg   <= ckp_next;
            busy_reg  <= busy_next;
            cnt_reg   <= cnt_next;
`ifdef TGMUX_TIMEOUT_EN
            to_cnt_reg   <= to_cnt_next;
            to_pulse_reg <= to_pulse_next;
            blocked_reg  <= blocked_next;
`endif
        end
    end

    assign gnt  = gnt_reg;
    assign ckn  = ckn_reg;
    assign ckp  = ckp_reg;
    assign sel  = sel_reg;
    assign busy = busy_reg;

endmodule
